// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC/branch unit: branch condition codes, FSM states
// and the word-alignment test used on redirect targets.
package pc_branch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  // Only the two low address bits decide word alignment.
  function automatic logic misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// ALU-to-PC-unit signal bundle: decode/flag inputs toward the unit, PC state back out.
interface pc_branch_unit_if #(
  parameter int CNT_W = 32
);
  import pc_branch_unit_pkg::*;

  logic             Stall;
  logic             Branch;
  logic             Jump;
  logic             JumpReg;
  logic [2:0]       Funct3;
  logic [XLEN-1:0]  ImmExt;
  logic [XLEN-1:0]  ALUResult;
  logic             Z;
  logic             N;
  logic             V;
  logic             C;

  logic [XLEN-1:0]  PC;
  logic [XLEN-1:0]  PCPlus4;
  logic             Taken;
  logic             Flush;
  logic             MisalignErr;
  logic [XLEN-1:0]  TrapPC;
  logic [CNT_W-1:0] InstRet;

  modport master (
    output Stall, Branch, Jump, JumpReg, Funct3, ImmExt, ALUResult, Z, N, V, C,
    input  PC, PCPlus4, Taken, Flush, MisalignErr, TrapPC, InstRet
  );

  modport slave (
    input  Stall, Branch, Jump, JumpReg, Funct3, ImmExt, ALUResult, Z, N, V, C,
    output PC, PCPlus4, Taken, Flush, MisalignErr, TrapPC, InstRet
  );

endinterface

// File: rtl/pc_branch_unit_branch_cond.sv
// Branch condition evaluation from the ALU flags of rs1-rs2 (C=1 means no borrow).
module pc_branch_unit_branch_cond
  import pc_branch_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  input  logic       c,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = z;
      F3_BNE:  cond = ~z;
      F3_BLT:  cond = n ^ v;
      F3_BGE:  cond = ~(n ^ v);
      F3_BLTU: cond = ~c;
      F3_BGEU: cond = c;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter owner: picks the next PC from jump/branch decode and ALU flags,
// pulses Flush after a committed redirect and locks up on a misaligned target.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  pc_branch_unit_if.slave    bus
);

  logic             cond;
  logic             pc_rel;
  logic             taken;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  next_pc;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  trap_pc_q, trap_pc_d;
  logic [CNT_W-1:0] inst_ret_q, inst_ret_d;
  logic             flush_q, flush_d;
  logic             err_q, err_d;

  pc_branch_unit_branch_cond u_branch_cond (
    .funct3 (bus.Funct3),
    .z      (bus.Z),
    .n      (bus.N),
    .v      (bus.V),
    .c      (bus.C),
    .cond   (cond)
  );

  // Next-PC mux: JALR beats JAL beats a taken branch; all additions wrap at 32 bits.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_rel   = bus.Jump | (bus.Branch & cond);
    taken    = bus.JumpReg | pc_rel;
    if (bus.JumpReg)
      next_pc = bus.ALUResult & ~32'h0000_0001;
    else if (pc_rel)
      next_pc = pc_q + bus.ImmExt;
    else
      next_pc = pc_plus4;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    trap_pc_d  = trap_pc_q;
    inst_ret_d = inst_ret_q;
    flush_d    = 1'b0;
    err_d      = err_q;
    case (state_q)
      ST_RUN: begin
        if (!bus.Stall) begin
          // Only redirects can misalign: the sequential path keeps PC word-aligned.
          if (taken && misaligned(next_pc[1:0])) begin
            state_d   = ST_TRAP;
            err_d     = 1'b1;
            trap_pc_d = pc_q;
          end else begin
            pc_d       = next_pc;
            inst_ret_d = inst_ret_q + CNT_W'(1);
            flush_d    = taken;
          end
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      trap_pc_q  <= '0;
      inst_ret_q <= '0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      trap_pc_q  <= trap_pc_d;
      inst_ret_q <= inst_ret_d;
      flush_q    <= flush_d;
      err_q      <= err_d;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.PCPlus4     = pc_plus4;
  assign bus.Taken       = taken;
  assign bus.Flush       = flush_q;
  assign bus.MisalignErr = err_q;
  assign bus.TrapPC      = trap_pc_q;
  assign bus.InstRet     = inst_ret_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: driver derives flags from rs1/rs2 operands and
// predicts outcomes with plain comparisons; a monitor pops predictions and compares.
module tb_pc_branch_unit;

  logic clk;
  logic rst;

  pc_branch_unit_if #(.CNT_W(32)) bus ();

  pc_branch_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk_comb;
    logic        taken;
    logic [31:0] pcp4;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        flush;
    logic        err;
    logic [31:0] tpc;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_cnt = 32'h0;
  logic        m_flush = 1'b0;
  logic        m_trap = 1'b0;
  logic [31:0] m_tpc = 32'h0;
  bit          m_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the expected response is computed from operand comparisons.
  task automatic drive(input bit r, input bit st, input bit br, input bit j, input bit jr,
                       input logic [2:0] f3, input logic [31:0] imm, input logic [31:0] alu,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] d;
    logic signed [31:0] sa, sb;
    bit cnd, tk;
    logic [31:0] tgt;
    @(negedge clk);
    d  = a - b;
    sa = a;
    sb = b;
    rst           = r;
    bus.Stall     = st;
    bus.Branch    = br;
    bus.Jump      = j;
    bus.JumpReg   = jr;
    bus.Funct3    = f3;
    bus.ImmExt    = imm;
    bus.ALUResult = alu;
    bus.Z         = (d == 32'h0);
    bus.N         = d[31];
    bus.C         = (a >= b);
    bus.V         = (a[31] != b[31]) && (d[31] != a[31]);
    case (f3)
      3'b000:  cnd = (a == b);
      3'b001:  cnd = (a != b);
      3'b100:  cnd = (sa < sb);
      3'b101:  cnd = (sa >= sb);
      3'b110:  cnd = (a < b);
      3'b111:  cnd = (a >= b);
      default: cnd = 1'b0;
    endcase
    tk = jr || j || (br && cnd);
    if (jr)                   tgt = {alu[31:1], 1'b0};
    else if (j || (br && cnd)) tgt = m_pc + imm;
    else                      tgt = m_pc + 32'd4;
    e.chk_comb = m_known;
    e.taken    = tk;
    e.pcp4     = m_pc + 32'd4;
    if (r) begin
      m_pc = 32'h0; m_cnt = 32'h0; m_flush = 1'b0; m_trap = 1'b0; m_tpc = 32'h0; m_known = 1'b1;
    end else if (m_trap || st) begin
      m_flush = 1'b0;
    end else if (tk && (tgt % 4 != 0)) begin
      m_trap = 1'b1; m_tpc = m_pc; m_flush = 1'b0;
    end else begin
      m_pc = tgt; m_cnt = m_cnt + 32'd1; m_flush = tk;
    end
    e.pc    = m_pc;
    e.cnt   = m_cnt;
    e.flush = m_flush;
    e.err   = m_trap;
    e.tpc   = m_tpc;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: combinational outputs are checked mid-cycle, registered ones after the edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        cur = q.pop_front();
        if (cur.chk_comb) begin
          chk("Taken", {31'b0, bus.Taken}, {31'b0, cur.taken});
          chk("PCPlus4", bus.PCPlus4, cur.pcp4);
        end
        @(posedge clk);
        #1;
        chk("PC", bus.PC, cur.pc);
        chk("InstRet", bus.InstRet, cur.cnt);
        chk("Flush", {31'b0, bus.Flush}, {31'b0, cur.flush});
        chk("MisalignErr", {31'b0, bus.MisalignErr}, {31'b0, cur.err});
        chk("TrapPC", bus.TrapPC, cur.tpc);
      end
    end
  end

  initial begin
    logic [31:0] rnd, imm, alu, a, b;
    bit r, st, br, j, jr;
    logic [2:0] f3;
    int wait_cyc;

    rst = 1'b1;
    bus.Stall = 1'b0; bus.Branch = 1'b0; bus.Jump = 1'b0; bus.JumpReg = 1'b0;
    bus.Funct3 = 3'b000; bus.ImmExt = 32'h0; bus.ALUResult = 32'h0;
    bus.Z = 1'b0; bus.N = 1'b0; bus.V = 1'b0; bus.C = 1'b0;

    do_reset();
    settle();
    chk("reset_pc", bus.PC, 32'h0);
    chk("reset_instret", bus.InstRet, 32'h0);
    chk("reset_flush", {31'b0, bus.Flush}, 32'h0);
    idle(3);
    settle();
    chk("idle_pc", bus.PC, 32'd12);
    chk("idle_instret", bus.InstRet, 32'd3);

    // BEQ taken backward from PC=8, then not taken.
    do_reset(); idle(2);
    drive(0, 0, 1, 0, 0, 3'b000, 32'hFFFF_FFF8, 32'h0, 32'd5, 32'd5);
    settle();
    chk("beq_pc", bus.PC, 32'h0);
    chk("beq_flush", {31'b0, bus.Flush}, 32'h1);
    idle(1);
    settle();
    chk("beq_flush_drop", {31'b0, bus.Flush}, 32'h0);
    idle(1);
    drive(0, 0, 1, 0, 0, 3'b000, 32'hFFFF_FFF8, 32'h0, 32'd5, 32'd6);
    settle();
    chk("beq_nt_pc", bus.PC, 32'd12);

    // BLT: N=1,V=1 not taken; N=1,V=0 taken. BLTU and BGEU taken.
    drive(0, 0, 1, 0, 0, 3'b100, 32'd16, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    drive(0, 0, 1, 0, 0, 3'b100, 32'd16, 32'h0, 32'hFFFF_FFFB, 32'd3);
    drive(0, 0, 1, 0, 0, 3'b110, 32'd8, 32'h0, 32'd1, 32'd2);
    drive(0, 0, 1, 0, 0, 3'b111, 32'd8, 32'h0, 32'd2, 32'd1);
    settle();
    chk("blt_bltu_bgeu_pc", bus.PC, 32'd48);

    // JALR priority over JAL, bit 0 cleared; then wrap past the top of memory.
    drive(0, 0, 0, 1, 1, 3'b000, 32'h40, 32'h101, 32'h0, 32'h0);
    settle();
    chk("jalr_pc", bus.PC, 32'h100);
    drive(0, 0, 0, 0, 1, 3'b000, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    idle(1);
    settle();
    chk("wrap_pc", bus.PC, 32'h0);

    // Misaligned JAL traps and freezes until reset.
    do_reset(); idle(1);
    drive(0, 0, 0, 1, 0, 3'b000, 32'd6, 32'h0, 32'h0, 32'h0);
    settle();
    chk("trap_err", {31'b0, bus.MisalignErr}, 32'h1);
    chk("trap_pc", bus.TrapPC, 32'd4);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 3'b000, 32'd8, 32'h0, 32'h0, 32'h0);
    settle();
    chk("trap_hold_pc", bus.PC, 32'd4);
    do_reset();
    settle();
    chk("trap_exit_pc", bus.PC, 32'h0);
    chk("trap_exit_err", {31'b0, bus.MisalignErr}, 32'h0);

    // JALR target ending in 2 traps even after bit 0 is cleared.
    drive(0, 0, 0, 0, 1, 3'b000, 32'h0, 32'h0000_0203, 32'h0, 32'h0);
    do_reset();

    // Stalled taken branch holds, then commits; reset while stalled.
    idle(1);
    drive(0, 1, 1, 0, 0, 3'b000, 32'h20, 32'h0, 32'd7, 32'd7);
    settle();
    chk("stall_pc", bus.PC, 32'd4);
    chk("stall_instret", bus.InstRet, 32'd1);
    drive(0, 0, 1, 0, 0, 3'b000, 32'h20, 32'h0, 32'd7, 32'd7);
    settle();
    chk("unstall_pc", bus.PC, 32'h24);
    chk("unstall_flush", {31'b0, bus.Flush}, 32'h1);
    drive(1, 1, 1, 0, 0, 3'b000, 32'h20, 32'h0, 32'd7, 32'd7);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 1) == 1);
      j  = ($urandom_range(0, 5) == 0);
      jr = ($urandom_range(0, 7) == 0);
      f3 = 3'($urandom_range(0, 7));
      rnd = $urandom;
      imm = ($urandom_range(0, 19) == 0) ? rnd : (rnd & 32'h0000_0FFC) - 32'h0000_0800;
      rnd = $urandom;
      alu = ($urandom_range(0, 9) == 0) ? rnd : (rnd & 32'hFFFF_FFF9);
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        2:       b = a + 32'($urandom_range(0, 3)) - 32'd2;
        default: b = $urandom;
      endcase
      drive(r, st, br, j, jr, f3, imm, alu, a, b);
    end

    settle();
    #2;
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
